// File: rtl/f1_reaction_timer.sv
// Reaction-time responder for the F1 start-light sequencer.
// Optional best-time register: define F1_REACT_BEST_EN.
module f1_reaction_timer #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] MAX_COUNT = 16'd9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic [7:0]       lights,
    input  logic             button,
    output logic             trigger,
    output logic [WIDTH-1:0] react_time,
    output logic             valid,
    output logic             false_start,
    output logic             timeout,
    output logic             busy,
    output logic [WIDTH-1:0] best_time
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ON,
        ARMED,
        ALL_ON,
        TIMING,
        DONE,
        FAULT
    } state_t;

    state_t           state;
    logic             btn_q;
    logic             rise;
    logic [WIDTH-1:0] count;

    assign rise = button & ~btn_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            btn_q       <= 1'b0;
            count       <= '0;
            trigger     <= 1'b0;
            react_time  <= '0;
            valid       <= 1'b0;
            false_start <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            btn_q   <= button;
            trigger <= 1'b0;
            valid   <= 1'b0;
            unique case (state)
                IDLE, DONE, FAULT: begin
                    if (start) begin
                        trigger     <= 1'b1;
                        false_start <= 1'b0;
                        timeout     <= 1'b0;
                        busy        <= 1'b1;
                        state       <= WAIT_ON;
                    end
                end
                WAIT_ON: begin
                    if (rise) begin
                        false_start <= 1'b1;
                        busy        <= 1'b0;
                        state       <= FAULT;
                    end else if (lights != 8'h00) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (rise) begin
                        false_start <= 1'b1;
                        busy        <= 1'b0;
                        state       <= FAULT;
                    end else if (lights == 8'hFF) begin
                        state <= ALL_ON;
                    end else if (lights == 8'h00) begin
                        state <= WAIT_ON;
                    end
                end
                ALL_ON: begin
                    // A press coinciding with lights-out is still early.
                    if (rise) begin
                        false_start <= 1'b1;
                        busy        <= 1'b0;
                        state       <= FAULT;
                    end else if (lights == 8'h00) begin
                        count <= '0;
                        state <= TIMING;
                    end
                end
                TIMING: begin
                    if (rise) begin
                        react_time <= count;
                        valid      <= 1'b1;
                        busy       <= 1'b0;
                        state      <= DONE;
                    end else if (count == MAX_COUNT) begin
                        react_time <= MAX_COUNT;
                        timeout    <= 1'b1;
                        valid      <= 1'b1;
                        busy       <= 1'b0;
                        state      <= DONE;
                    end else if (tick) begin
                        count <= count + WIDTH'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef F1_REACT_BEST_EN
    // Updated on the capture edge, so it moves together with react_time.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_time <= '1;
        end else if (state == TIMING && rise && count < best_time) begin
            best_time <= count;
        end
    end
`else
    assign best_time = '1;
`endif

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Scoreboard bench for f1_reaction_timer with a tick-counting model.
module tb_f1_reaction_timer;

    localparam int          W    = 16;
    localparam logic [15:0] MAXC = 16'd60;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    lights = 8'h00;
    logic          button = 1'b0;
    logic          trigger;
    logic [W-1:0]  react_time;
    logic          valid;
    logic          false_start;
    logic          timeout;
    logic          busy;
    logic [W-1:0]  best_time;

    f1_reaction_timer #(
        .WIDTH     (W),
        .MAX_COUNT (MAXC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .start       (start),
        .lights      (lights),
        .button      (button),
        .trigger     (trigger),
        .react_time  (react_time),
        .valid       (valid),
        .false_start (false_start),
        .timeout     (timeout),
        .busy        (busy),
        .best_time   (best_time)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rt;
        logic        to;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          trig_seen = 0;
    int          trig_exp = 0;
    logic [15:0] last_m = 16'h0000;
    logic [15:0] best_m = 16'hFFFF;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_best();
`ifdef F1_REACT_BEST_EN
        return best_m;
`else
        return 16'hFFFF;
`endif
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (trigger) trig_seen++;
            if (valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL valid_unexpected got react_time %0d want no valid",
                             react_time);
                end else begin
                    e = exp_q.pop_front();
                    chk("react_time", 32'(react_time), 32'(e.rt));
                    chk("timeout_at_valid", 32'(timeout), 32'(e.to));
                    chk("fs_at_valid", 32'(false_start), 0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] rt, input logic to);
        exp_q.push_back('{rt: rt, to: to});
        last_m = rt;
        if (!to && rt < best_m) best_m = rt;
    endtask

    task automatic reset_checks();
        chk("rst_trigger", 32'(trigger), 0);
        chk("rst_react", 32'(react_time), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_fs", 32'(false_start), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_best", 32'(best_time), 32'hFFFF);
        last_m = 16'h0000;
        best_m = 16'hFFFF;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        chk("trigger", 32'(trigger), 1);
        chk("busy_start", 32'(busy), 1);
        chk("fs_cleared", 32'(false_start), 0);
        chk("to_cleared", 32'(timeout), 0);
        trig_exp++;
        repeat ($urandom_range(0, 2)) step();
        start = 1'b0;
    endtask

    task automatic ramp(input logic [7:0] upto, input bit ab);
        logic [7:0] v;
        bit         used;
        v    = 8'h01;
        used = 1'b0;
        while (1) begin
            lights = v;
            tick   = 1'($urandom_range(0, 1));
            start  = 1'($urandom_range(0, 1));
            step();
            if (v == upto) break;
            if (ab && !used && v == 8'h03 && $urandom_range(0, 1) == 1) begin
                used   = 1'b1;
                lights = 8'h00;
                start  = 1'b0;
                step();
                v = 8'h01;
            end else begin
                v = {v[6:0], 1'b1};
            end
        end
        start = 1'b0;
    endtask

    // mode 0: press after target ticks, 1: never press, 2: reset at target
    task automatic timing(input int mode, input int target, input bit tp);
        int cnt;
        lights = 8'h00;
        tick   = 1'($urandom_range(0, 1));
        step();
        cnt = 0;
        while (1) begin
            if (mode == 0 && cnt == target) begin
                button = 1'b1;
                tick   = tp ? 1'b1 : 1'($urandom_range(0, 1));
                push(16'(cnt), 1'b0);
                step();
                button = 1'b0;
                break;
            end
            if (mode == 2 && cnt == target) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                reset_checks();
                break;
            end
            if (cnt == int'(MAXC)) begin
                tick = 1'($urandom_range(0, 1));
                push(MAXC, 1'b1);
                step();
                break;
            end
            tick = 1'($urandom_range(0, 1));
            step();
            if (tick) cnt++;
        end
        tick = 1'b0;
    endtask

    task automatic attempt(input int mode, input int target, input bit tp);
        do_start();
        ramp(8'hFF, 1'b1);
        timing(mode, target, tp);
        if (mode != 2) begin
            repeat (2) step();
            chk("busy_done", 32'(busy), 0);
            chk("fs_done", 32'(false_start), 0);
            chk("to_done", 32'(timeout), (mode == 1) ? 1 : 0);
            chk("react_hold", 32'(react_time), 32'(last_m));
            chk("best", 32'(best_time), 32'(exp_best()));
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        reset_checks();
        step();
        reset_checks();

        attempt(0, 37, 1'b0);

        do_start();
        ramp(8'h03, 1'b0);
        lights = 8'h07;
        button = 1'b1;
        step();
        button = 1'b0;
        step();
        chk("fs_set", 32'(false_start), 1);
        chk("fs_busy", 32'(busy), 0);
        chk("fs_react", 32'(react_time), 32'(last_m));
        do_start();
        ramp(8'hFF, 1'b0);
        lights = 8'h00;
        button = 1'b1;
        step();
        button = 1'b0;
        step();
        chk("fs_lights_out", 32'(false_start), 1);
        chk("fs_lo_busy", 32'(busy), 0);

        attempt(0, 50, 1'b0);
        attempt(0, 30, 1'b0);
        attempt(0, 40, 1'b0);
        attempt(1, 0, 1'b0);
`ifdef F1_REACT_BEST_EN
        chk("best_is_30", 32'(best_time), 30);
`else
        chk("best_tied", 32'(best_time), 32'hFFFF);
`endif
        attempt(0, 5, 1'b1);
        attempt(0, int'(MAXC), 1'b0);
        attempt(2, 10, 1'b0);
        attempt(0, 0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            attempt(($urandom_range(0, 3) == 0) ? 1 : 0,
                    $urandom_range(0, int'(MAXC)), 1'($urandom_range(0, 1)));
        end

        repeat (4) step();
        chk("triggers", 32'(trig_seen), 32'(trig_exp));
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
